// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  // Memory is word-addressed; the byte offset is dropped, never flagged.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select between fetch and data port, with a DM streak limiter
// that hands the slot to fetch after MAX_STREAK consecutive DM wins.
module mem_arb_priority #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_valid,
  input  logic dm_valid,
  input  logic accept,
  output logic grant_if,
  output logic grant_dm
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] streak;
  logic             starve_if;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_W'(MAX_STREAK)) return CNT_W'(MAX_STREAK);
    return v + CNT_W'(1);
  endfunction

  assign starve_if = (streak == CNT_W'(MAX_STREAK));

  always_comb begin
    grant_dm = dm_valid & ~(if_valid & starve_if);
    grant_if = if_valid & ~grant_dm;
  end

  // Streak only moves on an actual handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      streak <= '0;
    end else if (accept) begin
      if (grant_dm)      streak <= if_valid ? sat_inc(streak) : '0;
      else if (grant_if) streak <= '0;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by instruction fetch and the MEM-stage data port;
// one access in flight, DM priority with fetch anti-starvation.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  input  logic [BE_W-1:0]   dm_req_be,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_mem
);

  localparam int LAT_W = 4;

  arb_state_e       state, state_nxt;
  owner_e           owner_p0;
  logic             store_p0;
  logic [LAT_W-1:0] lat_cnt;
  logic             can_accept;
  logic             grant_if, grant_dm;
  logic             handshake;
  logic             rsp_fire;

  mem_arb_priority #(.MAX_STREAK(MAX_STREAK)) u_priority (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_req_valid),
    .dm_valid (dm_req_valid),
    .accept   (can_accept),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  assign can_accept   = (state == IDLE) || (state == RESP);
  assign if_req_ready = can_accept & grant_if;
  assign dm_req_ready = can_accept & grant_dm;
  assign handshake    = if_req_ready | dm_req_ready;
  assign stall_fetch  = if_req_valid & ~if_req_ready;
  assign stall_mem    = dm_req_valid & ~dm_req_ready;
  assign rsp_fire     = (state == WAIT) && (lat_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = handshake ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: handshake captures the request into control registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      owner_p0     <= OWN_IF;
      store_p0     <= 1'b0;
      lat_cnt      <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      mem_en       <= handshake;
      mem_we       <= dm_req_ready & dm_req_we;
      if_rsp_valid <= rsp_fire && (owner_p0 == OWN_IF);
      dm_rsp_valid <= rsp_fire && (owner_p0 == OWN_DM);
      if (handshake) begin
        owner_p0 <= dm_req_ready ? OWN_DM : OWN_IF;
        store_p0 <= dm_req_ready & dm_req_we;
      end
      if (state == ISSUE)                 lat_cnt <= LAT_W'(MEM_LAT - 1);
      else if (state == WAIT && !rsp_fire) lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // Stage p1: memory payload on handshake, response data at end of latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      if_rsp_data <= '0;
      dm_rsp_data <= '0;
    end else begin
      if (handshake) begin
        mem_addr  <= word_align(dm_req_ready ? dm_req_addr : if_req_addr);
        mem_wdata <= dm_req_ready ? dm_req_wdata : '0;
        mem_be    <= (dm_req_ready & dm_req_we) ? dm_req_be : '1;
      end
      if (rsp_fire) begin
        if (owner_p0 == OWN_DM) dm_rsp_data <= store_p0 ? '0 : mem_rdata;
        else                    if_rsp_data <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between two requesters of the pipelined MIPS core: instruction fetch (IF) and the MEM-stage load/store port (DM).
- Sits between the fetch/memory stages and the memory macro.
- Issues one access at a time, returns the response, and drives stall outputs back to the pipeline.
- Priority goes to DM; a streak limiter prevents fetch starvation.

Parameters:
MEM_LAT, 1, memory read latency in cycles after mem_en; legal 1..15
MAX_STREAK, 4, max consecutive DM grants while IF is waiting; legal 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
if_req_valid  in  1  fetch request
if_req_addr  in  32  fetch byte address
if_req_ready  out  1  fetch request accepted this cycle
if_rsp_valid  out  1  fetch data valid, 1-cycle pulse
if_rsp_data  out  32  fetched instruction
dm_req_valid  in  1  data request
dm_req_we  in  1  1=store, 0=load
dm_req_addr  in  32  data byte address
dm_req_wdata  in  32  store data
dm_req_be  in  4  store byte enables
dm_req_ready  out  1  data request accepted
dm_rsp_valid  out  1  load data / store ack, 1-cycle pulse
dm_rsp_data  out  32  load data; 0 for stores
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  32  word-aligned address
mem_wdata  out  32  write data
mem_be  out  4  byte enables (4'hF for reads)
mem_rdata  in  32  read data
stall_fetch  out  1  if_req_valid & ~if_req_ready
stall_mem  out  1  dm_req_valid & ~dm_req_ready

Behaviour:
- Reset: sampled at posedge when reset==0.
  - State to IDLE, streak to 0.
  - All registered outputs to 0: mem_*, *_rsp_valid, *_rsp_data.
  - Reset mid-transaction discards the outstanding access; no response is issued.
- States and transitions:
  - IDLE -> ISSUE on a handshake.
  - ISSUE (1 cycle) -> WAIT.
  - WAIT counts MEM_LAT cycles -> RESP.
  - RESP (1 cycle) -> ISSUE on a new handshake, else IDLE.
- Ready: asserted combinationally, only in IDLE or RESP, and only to the arbitration winner. The loser's ready is 0.
- Arbitration, when both request valid:
  - DM wins unless streak==MAX_STREAK, in which case IF wins.
  - Only one requester valid: that requester wins.
- Streak counter:
  - DM grant with if_req_valid=1: increment, saturating at MAX_STREAK.
  - DM grant with if_req_valid=0: clear.
  - Any IF grant: clear.
- Timing for a handshake in cycle N:
  - Request payload is captured at the end of N.
  - ISSUE in N+1: mem_en=1 for exactly one cycle; mem_addr={addr[31:2],2'b00}.
  - mem_we/mem_be/mem_wdata come from the captured payload; for fetches and loads, mem_we=0 and mem_be=4'hF.
  - mem_rdata is sampled at the end of cycle N+1+MEM_LAT.
  - RESP in N+2+MEM_LAT: the owning requester's rsp_valid=1, rsp_data registered. Stores return data 0.
- Throughput: a new handshake is allowed in the RESP cycle, giving back-to-back accesses every MEM_LAT+2 cycles.
- Non-winning rsp_valid stays 0; rsp_data holds its last value.
- Address bits [1:0] are ignored; no misalignment error.
- Requesters hold valid and payload stable until ready. The arbiter captures the payload only at the handshake.
- stall_fetch and stall_mem are combinational, per the equations in Ports.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_IF, OWN_DM}
  - ADDR_W=32, DATA_W=32, BE_W=4
- One sub-module, mem_arb_priority: the winner-select logic plus the streak counter. Outputs are grant_if and grant_dm.

Test Plan:
1. MEM_LAT=1, IF only, addr 0x104 at cycle 0 -> mem_en=1 in cycle 1 with mem_addr=0x104; model returns 0x2402000A; if_rsp_valid in cycle 3 with data 0x2402000A; stall_fetch=0 in cycle 0.
2. IF (0x200) and DM load (0x1000) both valid in cycle 0 -> dm_req_ready=1, if_req_ready=0, stall_fetch=1; DM accepted first, IF accepted in the DM RESP cycle.
3. MAX_STREAK=4, DM valid continuously and IF valid continuously -> grant order D,D,D,D,I,D,D,D,D,I.
4. Store to 0x1003 with be=4'b0011, wdata 0xDEADBEEF -> mem_addr=0x1000, mem_we=1, mem_be=0011; dm_rsp_valid at N+2+MEM_LAT with data 0.
5. Reset driven low during WAIT -> after the next posedge: state IDLE, mem_en=0, no rsp_valid ever for that access; a fresh request after reset completes normally.
6. MEM_LAT=3, back-to-back IF fetches 0x0, 0x4, 0x8 -> handshakes at cycles 0, 5, 10; responses at cycles 5, 10, 15.
